// File: rtl/lcd_timing_gen.sv
// Source-side LCD timing generator: raster counters, graceful start/stop FSM and a
// three-stage output pipeline. Define TG_PATTERN_EN for the internal colour-bar source.
module lcd_timing_gen #(
  parameter int P_DAT_BIT = 6,
  parameter int H_ACT     = 480,
  parameter int H_FP      = 8,
  parameter int H_SYNC    = 4,
  parameter int H_BP      = 43,
  parameter int V_ACT     = 272,
  parameter int V_FP      = 4,
  parameter int V_SYNC    = 4,
  parameter int V_BP      = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [P_DAT_BIT-1:0] pix_r,
  input  logic [P_DAT_BIT-1:0] pix_g,
  input  logic [P_DAT_BIT-1:0] pix_b,
  output logic                 pix_req,
  output logic                 hs,
  output logic                 vs,
  output logic                 de,
  output logic [10:0]          hpos,
  output logic [9:0]           vpos,
  output logic [P_DAT_BIT-1:0] rdata,
  output logic [P_DAT_BIT-1:0] gdata,
  output logic [P_DAT_BIT-1:0] bdata,
  output logic                 frame_start,
  output logic                 busy
);

  localparam int H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int BAR_W   = H_ACT / 8;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT_L  = 11'(H_ACT);
  localparam logic [10:0] H_SYNC_B = 11'(H_ACT + H_FP);
  localparam logic [10:0] H_SYNC_E = 11'(H_ACT + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT_L  = 10'(V_ACT);
  localparam logic [9:0]  V_SYNC_B = 10'(V_ACT + V_FP);
  localparam logic [9:0]  V_SYNC_E = 10'(V_ACT + V_FP + V_SYNC);

  typedef enum logic [1:0] {IDLE, RUN, STOP_PEND} state_t;

  // Bar index saturates at 7 so the last bar absorbs the H_ACT remainder.
  function automatic logic [2:0] bar_idx(input logic [10:0] x);
    logic [2:0] b;
    b = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (x >= 11'(k * BAR_W)) b = 3'(k);
    end
    return b;
  endfunction

  // Order white,yellow,cyan,green,magenta,red,blue,black maps to {r,g,b} = ~{i[1],i[2],i[0]}.
  function automatic logic [2:0] bar_rgb(input logic [10:0] x);
    logic [2:0] i;
    i = bar_idx(x);
    return {~i[1], ~i[2], ~i[0]};
  endfunction

  state_t                state_q, state_d;
  logic [10:0]           h_cnt_q, h_cnt_d;
  logic [9:0]            v_cnt_q, v_cnt_d;
  logic                  go, frame_end;
  logic                  act_s0, hs_s0, vs_s0, fs_s0;

  logic                  pix_req_q, pix_req_d;
  logic                  hs_p1_q, hs_p1_d, vs_p1_q, vs_p1_d, fs_p1_q, fs_p1_d;
  logic [10:0]           hpos_p1_q, hpos_p1_d;
  logic [9:0]            vpos_p1_q, vpos_p1_d;
  logic                  de_p2_q, de_p2_d, hs_p2_q, hs_p2_d, vs_p2_q, vs_p2_d, fs_p2_q, fs_p2_d;
  logic [10:0]           hpos_p2_q, hpos_p2_d;
  logic [9:0]            vpos_p2_q, vpos_p2_d;
  logic                  de_q, de_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;
  logic [10:0]           hpos_q, hpos_d;
  logic [9:0]            vpos_q, vpos_d;
  logic [P_DAT_BIT-1:0]  r_q, r_d, g_q, g_d, b_q, b_d;

  // A stop only takes effect on the last counter cycle of a frame.
  always_comb begin
    state_d   = state_q;
    go        = 1'b0;
    frame_end = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = RUN;
          go      = 1'b1;
        end
      end
      RUN: begin
        go = 1'b1;
        if (!en) state_d = frame_end ? IDLE : STOP_PEND;
      end
      STOP_PEND: begin
        go = 1'b1;
        if (en)             state_d = RUN;
        else if (frame_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (go) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = 11'd0;
        v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
      end else begin
        h_cnt_d = h_cnt_q + 11'd1;
      end
    end
    act_s0 = go && (h_cnt_q < H_ACT_L) && (v_cnt_q < V_ACT_L);
    hs_s0  = go && (h_cnt_q >= H_SYNC_B) && (h_cnt_q < H_SYNC_E);
    vs_s0  = go && (v_cnt_q >= V_SYNC_B) && (v_cnt_q < V_SYNC_E);
    fs_s0  = act_s0 && (h_cnt_q == 11'd0) && (v_cnt_q == 10'd0);
  end

  always_comb begin
    // stage 1: counter decode
    pix_req_d = act_s0;
    hs_p1_d   = hs_s0;
    vs_p1_d   = vs_s0;
    fs_p1_d   = fs_s0;
    hpos_p1_d = act_s0 ? h_cnt_q : hpos_p1_q;
    vpos_p1_d = act_s0 ? v_cnt_q : vpos_p1_q;
    // stage 2: delay, external pixel in flight
    de_p2_d   = pix_req_q;
    hs_p2_d   = hs_p1_q;
    vs_p2_d   = vs_p1_q;
    fs_p2_d   = fs_p1_q;
    hpos_p2_d = hpos_p1_q;
    vpos_p2_d = vpos_p1_q;
    // stage 3: outputs and pixel data
    de_d      = de_p2_q;
    hs_d      = hs_p2_q;
    vs_d      = vs_p2_q;
    fs_d      = fs_p2_q;
    hpos_d    = hpos_p2_q;
    vpos_d    = vpos_p2_q;
`ifdef TG_PATTERN_EN
    r_d = (de_p2_q && bar_rgb(hpos_p2_q)[2]) ? '1 : '0;
    g_d = (de_p2_q && bar_rgb(hpos_p2_q)[1]) ? '1 : '0;
    b_d = (de_p2_q && bar_rgb(hpos_p2_q)[0]) ? '1 : '0;
`else
    r_d = de_p2_q ? pix_r : '0;
    g_d = de_p2_q ? pix_g : '0;
    b_d = de_p2_q ? pix_b : '0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      pix_req_q <= 1'b0;
      hs_p1_q   <= 1'b0;
      vs_p1_q   <= 1'b0;
      fs_p1_q   <= 1'b0;
      hpos_p1_q <= '0;
      vpos_p1_q <= '0;
      de_p2_q   <= 1'b0;
      hs_p2_q   <= 1'b0;
      vs_p2_q   <= 1'b0;
      fs_p2_q   <= 1'b0;
      hpos_p2_q <= '0;
      vpos_p2_q <= '0;
      de_q      <= 1'b0;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      fs_q      <= 1'b0;
      hpos_q    <= '0;
      vpos_q    <= '0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
    end else begin
      state_q   <= state_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      pix_req_q <= pix_req_d;
      hs_p1_q   <= hs_p1_d;
      vs_p1_q   <= vs_p1_d;
      fs_p1_q   <= fs_p1_d;
      hpos_p1_q <= hpos_p1_d;
      vpos_p1_q <= vpos_p1_d;
      de_p2_q   <= de_p2_d;
      hs_p2_q   <= hs_p2_d;
      vs_p2_q   <= vs_p2_d;
      fs_p2_q   <= fs_p2_d;
      hpos_p2_q <= hpos_p2_d;
      vpos_p2_q <= vpos_p2_d;
      de_q      <= de_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      fs_q      <= fs_d;
      hpos_q    <= hpos_d;
      vpos_q    <= vpos_d;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
    end
  end

  assign pix_req     = pix_req_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign de          = de_q;
  assign hpos        = hpos_q;
  assign vpos        = vpos_q;
  assign rdata       = r_q;
  assign gdata       = g_q;
  assign bdata       = b_q;
  assign frame_start = fs_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen on a reduced raster; a frame-level reference model
// predicts every output each cycle. Honours TG_PATTERN_EN for the expected pixel data.
module tb_lcd_timing_gen;

  localparam int HA = 19, HF = 2, HS = 3, HB = 4;
  localparam int VA = 6, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int BW = HA / 8;

  logic       clk, rst, en;
  logic [5:0] pix_r, pix_g, pix_b;
  logic       pix_req, hs, vs, de, frame_start, busy;
  logic [10:0] hpos;
  logic [9:0]  vpos;
  logic [5:0]  rdata, gdata, bdata;

  int total = 0;
  int bad   = 0;
  int de_seen = 0;
  int fs_seen = 0;

  // {r,g,b} per bar: white, yellow, cyan, green, magenta, red, blue, black
  logic [2:0] bars [8] = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};

  lcd_timing_gen #(
    .P_DAT_BIT(6),
    .H_ACT(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACT(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .pix_req(pix_req), .hs(hs), .vs(vs), .de(de),
    .hpos(hpos), .vpos(vpos),
    .rdata(rdata), .gdata(gdata), .bdata(bdata),
    .frame_start(frame_start), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: raster index issued at each edge (-1 = none), newest first.
  int iss [3] = '{-1, -1, -1};
  int pos = 0;
  bit eng = 1'b0;
  int last_h = 0;
  int last_v = 0;

  function automatic bit is_act(input int p);
    return (p >= 0) && (p % HT < HA) && (p / HT < VA);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      iss = '{-1, -1, -1};
      pos = 0; eng = 1'b0; last_h = 0; last_v = 0;
    end else begin
      iss[2] = iss[1];
      iss[1] = iss[0];
      if (eng || en) begin
        iss[0] = pos;
        if (pos == FT - 1) begin
          pos = 0;
          eng = en;
        end else begin
          pos = pos + 1;
          eng = 1'b1;
        end
      end else begin
        iss[0] = -1;
      end
      if (is_act(iss[2])) begin
        last_h = iss[2] % HT;
        last_v = iss[2] / HT;
      end
    end
  end

  // External pixel source: answers each request one cycle later, garbage otherwise.
  int src_cnt = 0;
  bit src_prev = 1'b0;
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      src_cnt = 0;
      src_prev = 1'b0;
    end else begin
      if (src_prev) begin
        pix_r = 6'(src_cnt % HA);
        pix_g = 6'((src_cnt / HA) % VA);
        pix_b = 6'(src_cnt % HA) ^ 6'h15;
        src_cnt = src_cnt + 1;
      end else begin
        pix_r = 6'($urandom);
        pix_g = 6'($urandom);
        pix_b = 6'($urandom);
      end
      src_prev = pix_req;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    int p, h, v, bi;
    bit act;
    logic [2:0] c;
    logic [5:0] er, eg, eb;
    p = iss[2];
    h = (p >= 0) ? p % HT : 0;
    v = (p >= 0) ? p / HT : 0;
    act = is_act(p);
    er = '0; eg = '0; eb = '0;
    if (act) begin
`ifdef TG_PATTERN_EN
      bi = (h / BW > 7) ? 7 : h / BW;
      c = bars[bi];
      er = c[2] ? 6'h3f : 6'h00;
      eg = c[1] ? 6'h3f : 6'h00;
      eb = c[0] ? 6'h3f : 6'h00;
`else
      bi = 0;
      c = bars[bi];
      er = 6'(h);
      eg = 6'(v);
      eb = 6'(h) ^ 6'h15;
`endif
    end
    chk("pix_req", 32'(pix_req), 32'(is_act(iss[0])));
    chk("de", 32'(de), 32'(act));
    chk("hs", 32'(hs), 32'((p >= 0) && h >= HA + HF && h < HA + HF + HS));
    chk("vs", 32'(vs), 32'((p >= 0) && v >= VA + VF && v < VA + VF + VS));
    chk("frame_start", 32'(frame_start), 32'(act && h == 0 && v == 0));
    chk("busy", 32'(busy), 32'(eng));
    chk("hpos", 32'(hpos), 32'(last_h));
    chk("vpos", 32'(vpos), 32'(last_v));
    chk("rdata", 32'(rdata), 32'(er));
    chk("gdata", 32'(gdata), 32'(eg));
    chk("bdata", 32'(bdata), 32'(eb));
    if (de === 1'b1) de_seen++;
    if (frame_start === 1'b1) fs_seen++;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      check_all();
    end
  endtask

  task automatic wait_pos(input int target);
    int g;
    g = 0;
    while (pos != target && g < 2 * FT) begin
      step(1);
      g++;
    end
    chk("wait_pos_timeout", 32'(pos), 32'(target));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0;
    pix_r = '0; pix_g = '0; pix_b = '0;
    repeat (2) @(negedge clk);
    check_all();
    rst = 1'b0;
    step(4);

    en = 1'b1;
    de_seen = 0; fs_seen = 0;
    step(FT + 2);
    chk("de_per_frame", 32'(de_seen), 32'(HA * VA));
    chk("fs_per_frame", 32'(fs_seen), 32'(1));
    step(FT / 2);

    // graceful stop mid-frame
    wait_pos(3 * HT + 5);
    en = 1'b0;
    step(2 * FT);

    // stop requested, then withdrawn before the frame ends
    en = 1'b1;
    wait_pos(3 * HT);
    en = 1'b0;
    wait_pos(8 * HT + 1);
    en = 1'b1;
    step(FT);

    // en drops exactly on the last counter cycle
    wait_pos(FT - 1);
    en = 1'b0;
    step(FT + 4);

    // random run/stop requests
    en = 1'b1;
    repeat (4 * FT) begin
      if ($urandom_range(0, 199) == 0) en = ~en;
      step(1);
    end

    // asynchronous reset mid-line
    en = 1'b1;
    wait_pos(4 * HT + 7);
    #2 rst = 1'b1;
    #1 check_all();
    step(2);
    rst = 1'b0;
    step(FT + 4);
    en = 1'b0;
    step(FT + 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
